// File: rtl/fir_stream_feeder_if.sv
// Host-stream and FIR-side bus of fir_stream_feeder.
// Defining FIR_FEEDER_SAT_EN adds the sat_flag result qualifier.
interface fir_stream_feeder_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] fir_sample;
   logic        fir_new_sample;
   logic [31:0] fir_out_h;
   logic [31:0] fir_out_l;
   logic [63:0] m_data;
   logic        m_valid;
   logic        m_ready;
`ifdef FIR_FEEDER_SAT_EN
   logic        sat_flag;
`endif

   modport master (
      output s_data, s_valid, fir_out_h, fir_out_l, m_ready,
      input  s_ready, fir_sample, fir_new_sample, m_data, m_valid
`ifdef FIR_FEEDER_SAT_EN
      , input sat_flag
`endif
   );

   modport slave (
      input  s_data, s_valid, fir_out_h, fir_out_l, m_ready,
      output s_ready, fir_sample, fir_new_sample, m_data, m_valid
`ifdef FIR_FEEDER_SAT_EN
      , output sat_flag
`endif
   );
endinterface

// File: rtl/fir_stream_feeder.sv
// Feeds one host sample at a time into the 49-tap FIR and returns its 64-bit result.
// Optional FIR_FEEDER_SAT_EN: result is arithmetic-shifted by SHIFT and saturated to signed 32 bits.
module fir_stream_feeder #(
   parameter int unsigned STROBE_CYC = 2,
   parameter int unsigned RESULT_LAT = 5,
   parameter int unsigned SHIFT      = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   fir_stream_feeder_if.slave  bus,
   output logic                busy,
   output logic [15:0]         sample_cnt
);

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, HOLD} state_t;

   localparam logic [3:0] STROBE_LAST  = 4'(STROBE_CYC - 1);
   localparam logic [3:0] CAPTURE_LAST = 4'(RESULT_LAT - 1);

   generate
      if (STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_strobe
         $error("fir_stream_feeder: STROBE_CYC must be in 1..15");
      end
      if (RESULT_LAT <= STROBE_CYC || RESULT_LAT > 16) begin : g_bad_lat
         $error("fir_stream_feeder: RESULT_LAT must exceed STROBE_CYC and fit the 4-bit counter");
      end
      if (SHIFT > 32) begin : g_bad_shift
         $error("fir_stream_feeder: SHIFT must be in 0..32");
      end
   endgenerate

   state_t      state;
   logic [3:0]  lat_cnt;
   logic [63:0] result_raw;
   logic [63:0] result_out;

   assign result_raw  = {bus.fir_out_h, bus.fir_out_l};
   assign busy        = (state != IDLE);
   assign bus.s_ready = (state == IDLE) && rst_n;

`ifdef FIR_FEEDER_SAT_EN
   localparam logic signed [63:0] SAT_MAX = 64'sh000000007FFFFFFF;
   localparam logic signed [63:0] SAT_MIN = -64'sh0000000080000000;

   logic signed [63:0] shifted;
   logic               sat_next;

   always_comb begin
      shifted    = $signed(result_raw) >>> SHIFT;
      sat_next   = 1'b0;
      result_out = {{32{shifted[31]}}, shifted[31:0]};
      if (shifted > SAT_MAX) begin
         result_out = SAT_MAX;
         sat_next   = 1'b1;
      end else if (shifted < SAT_MIN) begin
         result_out = SAT_MIN;
         sat_next   = 1'b1;
      end
   end
`else
   assign result_out = result_raw;
`endif

   // lat_cnt restarts at the first strobe-high cycle and times both the strobe and the capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         lat_cnt            <= '0;
         bus.fir_sample     <= '0;
         bus.fir_new_sample <= 1'b0;
         bus.m_data         <= '0;
         bus.m_valid        <= 1'b0;
         sample_cnt         <= '0;
`ifdef FIR_FEEDER_SAT_EN
         bus.sat_flag       <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.s_valid) begin
                  bus.fir_sample <= bus.s_data;
                  state          <= SETUP;
               end
            end
            SETUP: begin
               bus.fir_new_sample <= 1'b1;
               lat_cnt            <= '0;
               sample_cnt         <= sample_cnt + 16'd1;
               state              <= STROBE;
            end
            STROBE: begin
               lat_cnt <= lat_cnt + 4'd1;
               if (lat_cnt == STROBE_LAST) begin
                  bus.fir_new_sample <= 1'b0;
                  state              <= WAIT;
               end
            end
            WAIT: begin
               lat_cnt <= lat_cnt + 4'd1;
               if (lat_cnt == CAPTURE_LAST) begin
                  bus.m_data   <= result_out;
                  bus.m_valid  <= 1'b1;
`ifdef FIR_FEEDER_SAT_EN
                  bus.sat_flag <= sat_next;
`endif
                  state        <= HOLD;
               end
            end
            HOLD: begin
               if (bus.m_ready) begin
                  bus.m_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
